// File: rtl/rf_wb_queue.sv
// ============================================================================
// Module   : rf_wb_queue
// Purpose  : Register-file writeback queue; arbitrates the memory and ALU
//            result paths and exposes per-register pending checks.
// Option   : RF_WB_BYPASS_EN - load the output stage directly when empty.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_wb_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic [4:0]    mem_addr,
  input  logic [31:0]   mem_data,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [4:0]    alu_addr,
  input  logic [31:0]   alu_data,
  output logic          RegWrite,
  output logic [4:0]    WriteAddr,
  output logic [31:0]   WriteData,
  input  logic [4:0]    chk_addr1,
  input  logic [4:0]    chk_addr2,
  output logic          chk_busy1,
  output logic          chk_busy2,
  output logic [CW-1:0] count,
  output logic          idle
);

  localparam int            c_PTRW = $clog2(DEPTH);
  localparam logic [CW-1:0] c_FULL = CW'(DEPTH);

  logic [4:0]        r_addrMem [DEPTH];
  logic [31:0]       r_dataMem [DEPTH];
  logic [c_PTRW-1:0] r_wrPtr;
  logic [c_PTRW-1:0] r_rdPtr;
  logic [CW-1:0]     r_count;

  logic              w_notFull;
  logic              w_accMem;
  logic              w_accAlu;
  logic [4:0]        w_inAddr;
  logic [31:0]       w_inData;
  logic              w_inLive;
  logic              w_pop;
  logic              w_push;
  logic              w_bypass;
  logic [c_PTRW-1:0] w_off;
  logic              w_hit1;
  logic              w_hit2;

  assign w_notFull = (r_count < c_FULL);
  assign mem_ready = w_notFull;
  assign alu_ready = w_notFull && !mem_valid;
  assign w_accMem  = mem_valid && w_notFull;
  assign w_accAlu  = alu_valid && alu_ready;
  assign w_inAddr  = w_accMem ? mem_addr : alu_addr;
  assign w_inData  = w_accMem ? mem_data : alu_data;
  // Register 0 is hardwired; such results are accepted and dropped.
  assign w_inLive  = (w_accMem || w_accAlu) && (w_inAddr != 5'd0);
  assign w_pop     = (r_count != '0);

`ifdef RF_WB_BYPASS_EN
  assign w_bypass = w_inLive && !w_pop;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = w_inLive && !w_bypass;
  assign count  = r_count;
  assign idle   = (r_count == '0) && !RegWrite;

  // Entry storage needs no reset: occupancy is tracked by pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addrMem[r_wrPtr] <= w_inAddr;
      r_dataMem[r_wrPtr] <= w_inData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite  <= 1'b0;
      WriteAddr <= '0;
      WriteData <= '0;
    end else if (w_pop) begin
      RegWrite  <= 1'b1;
      WriteAddr <= r_addrMem[r_rdPtr];
      WriteData <= r_dataMem[r_rdPtr];
    end else if (w_bypass) begin
      RegWrite  <= 1'b1;
      WriteAddr <= w_inAddr;
      WriteData <= w_inData;
    end else begin
      RegWrite  <= 1'b0;
    end
  end

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    w_off  = '0;
    w_hit1 = RegWrite && (WriteAddr == chk_addr1);
    w_hit2 = RegWrite && (WriteAddr == chk_addr2);
    for (int i = 0; i < DEPTH; i++) begin
      w_off = c_PTRW'(i) - r_rdPtr;
      if (CW'(w_off) < r_count) begin
        if (r_addrMem[i] == chk_addr1) w_hit1 = 1'b1;
        if (r_addrMem[i] == chk_addr2) w_hit2 = 1'b1;
      end
    end
    chk_busy1 = (chk_addr1 != 5'd0) && w_hit1;
    chk_busy2 = (chk_addr2 != 5'd0) && w_hit2;
  end

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_queue.sv
// ============================================================================
// Module   : tb_rf_wb_queue
// Purpose  : Randomized self-checking bench for rf_wb_queue against a
//            queue-based reference model (honours RF_WB_BYPASS_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rf_wb_queue;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          mem_valid, mem_ready, alu_valid, alu_ready;
  logic [4:0]    mem_addr, alu_addr, chk_addr1, chk_addr2;
  logic [31:0]   mem_data, alu_data;
  logic          RegWrite, chk_busy1, chk_busy2, idle;
  logic [4:0]    WriteAddr;
  logic [31:0]   WriteData;
  logic [CW-1:0] count;

  rf_wb_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .RegWrite(RegWrite), .WriteAddr(WriteAddr), .WriteData(WriteData),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
    .count(count), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic        mRW;
  logic [4:0]  mWA;
  logic [31:0] mWD;
  int          checks = 0;
  int          failures = 0;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic busyOf(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    if (mRW && mWA == a) return 1'b1;
    foreach (q[i]) if (q[i].a == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [4:0] randAddr();
    if ($urandom_range(0, 9) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  task automatic modelReset();
    q.delete();
    mRW = 1'b0;
    mWA = '0;
    mWD = '0;
  endtask

  task automatic checkAll();
    checkValue("mem_ready", mem_ready, q.size() < DEPTH);
    checkValue("alu_ready", alu_ready, (q.size() < DEPTH) && !mem_valid);
    checkValue("count", count, q.size());
    checkValue("RegWrite", RegWrite, mRW);
    checkValue("WriteAddr", WriteAddr, mWA);
    checkValue("WriteData", WriteData, mWD);
    checkValue("idle", idle, (q.size() == 0) && !mRW);
    checkValue("chk_busy1", chk_busy1, busyOf(chk_addr1));
    checkValue("chk_busy2", chk_busy2, busyOf(chk_addr2));
  endtask

  // One clock edge of the reference: pop the head into the write port,
  // then append the accepted result (or bypass it when nothing was queued).
  task automatic modelEdge(input bit accM, input bit accA);
    ent_t e;
    int   oldSize;
    oldSize = q.size();
    if (oldSize > 0) begin
      e   = q.pop_front();
      mRW = 1'b1;
      mWA = e.a;
      mWD = e.d;
    end else begin
      mRW = 1'b0;
    end
    if (accM || accA) begin
      e.a = accM ? mem_addr : alu_addr;
      e.d = accM ? mem_data : alu_data;
      if (e.a != 5'd0) begin
`ifdef RF_WB_BYPASS_EN
        if (oldSize == 0) begin
          mRW = 1'b1;
          mWA = e.a;
          mWD = e.d;
        end else begin
          q.push_back(e);
        end
`else
        q.push_back(e);
`endif
      end
    end
  endtask

  // Unaccepted offers are held unchanged; otherwise a fresh offer is drawn.
  task automatic newOffers(input bit accM, input bit accA, input int rate);
    if (!mem_valid || accM) begin
      mem_valid = ($urandom_range(0, 99) < rate);
      mem_addr  = randAddr();
      mem_data  = $urandom();
    end
    if (!alu_valid || accA) begin
      alu_valid = ($urandom_range(0, 99) < rate);
      alu_addr  = randAddr();
      alu_data  = $urandom();
    end
    chk_addr1 = randAddr();
    chk_addr2 = randAddr();
  endtask

  initial begin
    bit accM, accA;
    int rate;
    mem_valid = 0; alu_valid = 0;
    mem_addr = 0; alu_addr = 0; mem_data = 0; alu_data = 0;
    chk_addr1 = 5'd1; chk_addr2 = 5'd2;
    modelReset();

    #2 rst_n = 1'b0;
    #1 checkAll();
    @(posedge clk);
    #1 checkAll();
    rst_n = 1'b1;

    for (int cyc = 0; cyc < 1500; cyc++) begin
      case ((cyc / 60) % 4)
        0: rate = 90;
        1: rate = 30;
        2: rate = 100;
        default: rate = 10;
      endcase

      if (cyc == 630) begin
        // Asynchronous reset mid-cycle while the queue is busy.
        #2;
        mem_valid = 1'b0;
        alu_valid = 1'b0;
        rst_n = 1'b0;
        modelReset();
        #1 checkAll();
        @(posedge clk);
        #1 checkAll();
        #2 rst_n = 1'b1;
      end

      @(negedge clk);
      checkAll();
      accM = mem_valid && (q.size() < DEPTH);
      accA = alu_valid && !mem_valid && (q.size() < DEPTH);
      @(posedge clk);
      modelEdge(accM, accA);
      #1;
      newOffers(accM, accA, rate);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
